// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose
//   Shares the CPU's single memory port between instruction fetch (IF) and
//   data load/store (D). One transaction is outstanding at a time. The winning
//   request is latched, issued to memory, and the memory response is routed
//   back to the requester that owns it.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   if_req_valid/addr, _ready     IF read request channel
//   if_resp_valid/rdata           IF read response (1-cycle pulse)
//   d_req_valid/we/addr/wdata/
//     wstrb, d_req_ready          D read/write request channel
//   d_resp_valid/rdata            D read data / write ack (1-cycle pulse)
//   mem_req_valid/ready/we/addr/
//     wdata/wstrb                 request channel to memory
//   mem_resp_valid/rdata          memory response (one per accepted request)
//   dbg_state                     current FSM state (0 IDLE, 1 REQ, 2 WAIT)
//
// Handshake: a transfer happens on a posedge where valid and ready are both
// high. A requester holds valid and every request field stable until it sees
// ready; ready never depends on anything but the requester's own valid, the
// competing valid, the streak counter and the FSM state.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  // instruction fetch
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_rdata,
  // data load/store
  input  logic                d_req_valid,
  input  logic                d_req_we,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_req_ready,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_rdata,
  // memory
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  // debug
  output logic [1:0]          dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(DATA_STREAK_MAX + 1);
  localparam logic [CNT_W-1:0] STREAK_LIMIT = CNT_W'(DATA_STREAK_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    streak_q, streak_d;
  logic                owner_d_q;   // 1 = D owns the outstanding transaction
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                if_resp_valid_q, d_resp_valid_q;
  logic [DATA_W-1:0]   if_resp_rdata_q, d_resp_rdata_q;

  logic if_win, d_win, if_grant, d_grant, resp_fire;

  // Arbitration: D has priority unless it has already taken DATA_STREAK_MAX
  // grants in a row while IF was kept waiting.
  always_comb begin
    if_win    = if_req_valid && (!d_req_valid || (streak_q == STREAK_LIMIT));
    d_win     = d_req_valid && !if_win;
    // Readies are combinational in IDLE; masking with reset keeps every
    // output low while reset is asserted.
    if_grant  = (state_q == ST_IDLE) && !reset && if_win;
    d_grant   = (state_q == ST_IDLE) && !reset && d_win;
    resp_fire = (state_q == ST_WAIT) && mem_resp_valid;
  end

  // Streak counts D grants made while IF was waiting; any cycle with IF idle
  // or an IF grant starts it over.
  always_comb begin
    streak_d = streak_q;
    if (!if_req_valid || if_grant) begin
      streak_d = '0;
    end else if (d_grant) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (if_grant || d_grant) state_d = ST_REQ;
      ST_REQ:  if (mem_req_ready)       state_d = ST_WAIT;
      // A response outside WAIT never reaches this branch, so stray or
      // post-reset responses are dropped.
      ST_WAIT: if (mem_resp_valid)      state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      streak_q        <= '0;
      owner_d_q       <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      if_resp_valid_q <= 1'b0;
      d_resp_valid_q  <= 1'b0;
      if_resp_rdata_q <= '0;
      d_resp_rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;

      if (if_grant) begin
        owner_d_q <= 1'b0;
        we_q      <= 1'b0;
        addr_q    <= if_req_addr;
        wdata_q   <= '0;
        wstrb_q   <= '0;
      end else if (d_grant) begin
        owner_d_q <= 1'b1;
        we_q      <= d_req_we;
        addr_q    <= d_req_addr;
        wdata_q   <= d_req_wdata;
        // Byte enables only mean something on writes; reads present zero.
        wstrb_q   <= d_req_we ? d_req_wstrb : '0;
      end

      if_resp_valid_q <= resp_fire && !owner_d_q;
      d_resp_valid_q  <= resp_fire && owner_d_q;
      if (resp_fire && !owner_d_q) if_resp_rdata_q <= mem_resp_rdata;
      if (resp_fire && owner_d_q)  d_resp_rdata_q  <= mem_resp_rdata;
    end
  end

  assign if_req_ready  = if_grant;
  assign d_req_ready   = d_grant;
  assign if_resp_valid = if_resp_valid_q;
  assign if_resp_rdata = if_resp_rdata_q;
  assign d_resp_valid  = d_resp_valid_q;
  assign d_resp_rdata  = d_resp_rdata_q;

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;

  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter. A memory model answers requests after a
// programmable delay; a transaction-level reference predicts grants, the
// memory request each grant produces, and the routed response.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SW     = DW / 8;
  localparam int STREAK = 4;
  localparam int QW     = 1 + AW + DW + SW;
  localparam int CW     = 80;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          if_req_valid, if_req_ready, if_resp_valid;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_resp_rdata;
  logic          d_req_valid, d_req_we, d_req_ready, d_resp_valid;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata, d_resp_rdata;
  logic [SW-1:0] d_req_wstrb;
  logic          mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [SW-1:0] mem_req_wstrb;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_rdata;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DATA_STREAK_MAX(STREAK)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- checking
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ":readies"},    CW'({if_req_ready, d_req_ready}), CW'(0));
    check_val({tag, ":resp_valid"}, CW'({if_resp_valid, d_resp_valid}), CW'(0));
    check_val({tag, ":if_rdata"},   CW'(if_resp_rdata), CW'(0));
    check_val({tag, ":d_rdata"},    CW'(d_resp_rdata), CW'(0));
    check_val({tag, ":mem_ctl"},    CW'({mem_req_valid, mem_req_we, mem_req_wstrb}), CW'(0));
    check_val({tag, ":mem_addr"},   CW'(mem_req_addr), CW'(0));
    check_val({tag, ":mem_wdata"},  CW'(mem_req_wdata), CW'(0));
  endtask

  // ---------------------------------------------------------------- reference
  // Transaction stage: 0 free, 1 issued to memory, 2 awaiting memory response.
  int            stage;
  int            streak_m;        // D grants in a row while IF waited
  bit            owner_d_m, cur_we_m;
  bit            exp_if_resp, exp_d_resp, exp_rd_m;
  logic [DW-1:0] exp_rdata_m;
  logic [QW-1:0] exp_q[$];        // {we, addr, wdata, wstrb} per granted request
  bit            grant_log[$];    // 1 = D granted, 0 = IF granted
  logic [DW-1:0] mem_m [logic [AW-1:0]];

  // memory responder knobs/state
  int            resp_cnt, dly_min, dly_max, stall_pct, stall_left;
  bit            spur_en;
  logic [DW-1:0] resp_data;

  // request driver mode: 0 manual, 1 random, 2 both always requesting
  int            drv_mode;

  // observation counters
  int            cyc, grant_cyc, if_resp_cyc, if_resp_cnt, d_resp_cnt, mreq_cycles;
  logic [DW-1:0] last_if_rdata;

  function automatic logic [DW-1:0] default_word(input logic [AW-1:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return 32'h1000 + AW'($urandom_range(0, 15) * 4);
  endfunction

  task automatic model_reset();
    stage       = 0;
    streak_m    = 0;
    exp_if_resp = 1'b0;
    exp_d_resp  = 1'b0;
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive_reqs(input bit g_if, input bit g_d);
    if (g_if || !if_req_valid) begin
      case (drv_mode)
        1: begin if_req_valid = ($urandom_range(0, 3) != 0); if_req_addr = rand_addr(); end
        2: begin if_req_valid = 1'b1; if_req_addr = rand_addr(); end
        default: if (g_if) if_req_valid = 1'b0;
      endcase
    end
    if (g_d || !d_req_valid) begin
      case (drv_mode)
        1, 2: begin
          d_req_valid = (drv_mode == 2) || ($urandom_range(0, 3) != 0);
          d_req_we    = $urandom_range(0, 1) == 1;
          d_req_addr  = rand_addr();
          d_req_wdata = $urandom;
          d_req_wstrb = SW'($urandom_range(0, 15));
        end
        default: if (g_d) d_req_valid = 1'b0;
      endcase
    end
  endtask

  task automatic drive_mem();
    mem_resp_valid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = resp_data;
      end
    end else if (spur_en && stage == 0 && $urandom_range(0, 7) == 0) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = $urandom;
    end
    if (stall_left > 0) begin
      stall_left--;
      mem_req_ready = 1'b0;
    end else begin
      mem_req_ready = ($urandom_range(0, 99) >= stall_pct);
    end
  endtask

  // One clock: compare at the negedge, then advance the reference and drive
  // new inputs just after the posedge.
  task automatic step();
    bit            e_if, e_d, wr;
    logic [QW-1:0] e;
    logic [AW-1:0] a;
    logic [DW-1:0] cur, wd;
    logic [SW-1:0] ws;
    @(negedge clk);
    cyc++;
    e_if = 1'b0;
    e_d  = 1'b0;
    if (!reset && stage == 0) begin
      // D first; IF only when alone or when D has used up its streak.
      if (d_req_valid && !(if_req_valid && streak_m == STREAK)) e_d = 1'b1;
      else if (if_req_valid) e_if = 1'b1;
    end
    check_val("if_req_ready",  CW'(if_req_ready),  CW'(e_if));
    check_val("d_req_ready",   CW'(d_req_ready),   CW'(e_d));
    check_val("mem_req_valid", CW'(mem_req_valid), CW'(stage == 1));
    check_val("if_resp_valid", CW'(if_resp_valid), CW'(exp_if_resp));
    check_val("d_resp_valid",  CW'(d_resp_valid),  CW'(exp_d_resp));
    if (exp_if_resp) check_val("if_resp_rdata", CW'(if_resp_rdata), CW'(exp_rdata_m));
    if (exp_d_resp && exp_rd_m) check_val("d_resp_rdata", CW'(d_resp_rdata), CW'(exp_rdata_m));
    if (mem_req_valid && exp_q.size() > 0)
      check_val("mem_req_fields",
                CW'({mem_req_we, mem_req_addr, (mem_req_we ? mem_req_wdata : {DW{1'b0}}), mem_req_wstrb}),
                CW'(exp_q[0]));
    if (if_resp_valid) begin
      if_resp_cnt++;
      if_resp_cyc   = cyc;
      last_if_rdata = if_resp_rdata;
    end
    if (d_resp_valid)  d_resp_cnt++;
    if (mem_req_valid) mreq_cycles++;
    if (e_if) grant_cyc = cyc;

    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      if (!if_req_valid || e_if) streak_m = 0;
      else if (e_d) streak_m++;
      exp_if_resp = 1'b0;
      exp_d_resp  = 1'b0;
      case (stage)
        0: if (e_if || e_d) begin
          stage     = 1;
          owner_d_m = e_d;
          grant_log.push_back(e_d);
          if (e_if) exp_q.push_back({1'b0, if_req_addr, {DW{1'b0}}, {SW{1'b0}}});
          else exp_q.push_back({d_req_we, d_req_addr, (d_req_we ? d_req_wdata : {DW{1'b0}}),
                                (d_req_we ? d_req_wstrb : {SW{1'b0}})});
        end
        1: if (mem_req_ready) begin
          e   = exp_q.pop_front();
          wr  = e[QW-1];
          a   = e[QW-2 -: AW];
          wd  = e[SW +: DW];
          ws  = e[SW-1:0];
          cur = mem_m.exists(a) ? mem_m[a] : default_word(a);
          if (wr) begin
            for (int b = 0; b < SW; b++) if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
            mem_m[a]  = cur;
            resp_data = $urandom;
          end else begin
            resp_data = cur;
          end
          cur_we_m = wr;
          resp_cnt = $urandom_range(dly_min, dly_max);
          stage    = 2;
        end
        2: if (mem_resp_valid) begin
          stage       = 0;
          exp_if_resp = !owner_d_m;
          exp_d_resp  = owner_d_m;
          exp_rdata_m = resp_data;
          exp_rd_m    = !cur_we_m;
        end
        default: ;
      endcase
    end
    drive_mem();
    drive_reqs(e_if, e_d);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    int n0;
    reset = 1'b1;
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h40; d_req_wdata = '0; d_req_wstrb = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    resp_cnt = 0; dly_min = 1; dly_max = 1; stall_pct = 0; stall_left = 0; spur_en = 1'b0;
    drv_mode = 0; cyc = 0; grant_cyc = 0; if_resp_cyc = 0; if_resp_cnt = 0; d_resp_cnt = 0;
    mreq_cycles = 0; last_if_rdata = '0; owner_d_m = 1'b0; cur_we_m = 1'b0; exp_rd_m = 1'b0;
    exp_rdata_m = '0; resp_data = '0;
    model_reset();

    // Reset state: all outputs low, even with a request pending.
    #2;
    check_zero("reset");
    step();
    step();
    d_req_valid = 1'b0;
    reset = 1'b0;
    step();

    // Single IF read, zero-wait memory: accept T, response T+3.
    mem_m[32'h100] = 32'hDEADBEEF;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h100;
    n0 = d_resp_cnt;
    for (int i = 0; i < 20 && if_resp_cnt == 0; i++) step();
    check_val("t1_latency", CW'(if_resp_cyc - grant_cyc), CW'(3));
    check_val("t1_rdata", CW'(last_if_rdata), CW'(32'hDEADBEEF));
    check_val("t1_no_d_resp", CW'(d_resp_cnt - n0), CW'(0));

    // IF and D together: D write wins, IF read of the same word follows.
    step();
    grant_log.delete();
    if_req_valid = 1'b1; if_req_addr = 32'h200;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h200;
    d_req_wdata = 32'h12345678; d_req_wstrb = 4'b1111;
    n0 = if_resp_cnt;
    for (int i = 0; i < 30 && if_resp_cnt == n0; i++) step();
    check_val("t2_grants", CW'(grant_log.size()), CW'(2));
    check_val("t2_first_is_d", CW'(grant_log[0]), CW'(1));
    check_val("t2_second_is_if", CW'(grant_log[1]), CW'(0));
    check_val("t2_if_rdata", CW'(last_if_rdata), CW'(32'h12345678));

    // D read with memory stalling 5 cycles.
    step();
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h200; d_req_wstrb = 4'b1010;
    stall_left = 5;
    mreq_cycles = 0;
    n0 = d_resp_cnt;
    for (int i = 0; i < 30 && d_resp_cnt == n0; i++) step();
    check_val("t4_req_cycles", CW'(mreq_cycles), CW'(6));
    check_val("t4_d_resp", CW'(d_resp_cnt - n0), CW'(1));

    // Both always requesting: D,D,D,D,IF repeating.
    step();
    grant_log.delete();
    drv_mode = 2;
    if_req_valid = 1'b1; if_req_addr = rand_addr();
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = rand_addr();
    for (int i = 0; i < 100 && grant_log.size() < 10; i++) step();
    check_val("t3_grant_count", CW'(grant_log.size() >= 10), CW'(1));
    for (int i = 0; i < 10; i++) check_val($sformatf("t3_grant%0d", i), CW'(grant_log[i]), CW'(i % 5 != 4));
    drv_mode = 0;
    for (int i = 0; i < 60 && (if_req_valid || d_req_valid || stage != 0); i++) step();
    check_val("t3_drained", CW'({if_req_valid, d_req_valid, stage == 0}), CW'(3'b001));

    // Reset in WAIT, stale memory response afterwards is ignored.
    dly_min = 4; dly_max = 4;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h1040;
    for (int i = 0; i < 20 && stage != 2; i++) step();
    check_val("t5_reached_wait", CW'(stage), CW'(2));
    reset = 1'b1;
    #1;
    check_zero("t5_reset");
    model_reset();
    resp_cnt = 2;
    n0 = if_resp_cnt + d_resp_cnt;
    step();
    reset = 1'b0;
    dly_min = 1; dly_max = 1;
    step();
    step();
    step();
    check_val("t5_no_stale_resp", CW'(if_resp_cnt + d_resp_cnt - n0), CW'(0));
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    for (int i = 0; i < 20 && if_resp_cnt + d_resp_cnt == n0; i++) step();
    check_val("t5_next_req", CW'(if_resp_cnt - n0 + d_resp_cnt), CW'(1));
    check_val("t5_next_rdata", CW'(last_if_rdata), CW'(32'hDEADBEEF));

    // Randomized traffic: stalls, variable latency, stray responses.
    drv_mode = 1; stall_pct = 30; dly_min = 1; dly_max = 3; spur_en = 1'b1;
    for (int i = 0; i < 1500; i++) step();
    drv_mode = 0; spur_en = 1'b0;
    for (int i = 0; i < 80 && (if_req_valid || d_req_valid || stage != 0); i++) step();
    step();
    check_val("final_idle", CW'({if_req_valid, d_req_valid, stage == 0, exp_q.size() == 0}), CW'(4'b0011));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
